// File: rtl/rip_axi_arbiter_if.sv
// rip_axi_arbiter_if
//   AXI4 bus bundle between the two-requester arbiter (master side) and an
//   AXI4 slave. Carries the full AW, W (with WID), B, AR and R channel sets.
// Parameters:
//   ADDR_WIDTH - address width of AWADDR/ARADDR
//   DATA_WIDTH - data width of WDATA/RDATA (WSTRB is DATA_WIDTH/8)
//   ID_WIDTH   - width of AWID/WID/BID/ARID/RID
// Modports:
//   master - drives AW*/W*/AR* payload+valid and BREADY/RREADY
//   slave  - drives AWREADY/WREADY/ARREADY and the B*/R* responses
interface rip_axi_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/rip_axi_arbiter.sv
// rip_axi_arbiter
//   Round-robin arbiter that lets two simple requesters share one AXI4 master
//   port. One single-beat transaction is outstanding at a time.
// Ports:
//   clk, rst        - clock (rising edge) and synchronous active-high reset
//   req/we          - per-requester request and write(1)/read(0) select
//   addr/wdata/wstrb- per-requester payload, requester i uses slice i
//   ack             - one-cycle pulse when requester i is granted
//   done            - one-cycle pulse when requester i's transaction ends
//   rdata/err       - read data and error flag, valid while done is high
//   busy            - high whenever the FSM is not IDLE
//   m_axi           - AXI4 master port (rip_axi_arbiter_if.master)
// Optional feature:
//   RIP_AXI_ARB_TIMEOUT_EN - when defined, a watchdog aborts a transaction
//   after TIMEOUT_CYCLES cycles without any AXI handshake (done + err=1).
module rip_axi_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req,
  input  logic [1:0]                we,
  input  logic [2*ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wdata,
  input  logic [2*DATA_WIDTH/8-1:0] wstrb,
  output logic [1:0]                ack,
  output logic [1:0]                done,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      err,
  output logic                      busy,
  rip_axi_arbiter_if.master         m_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  gnt_idx_s;
  logic                  aw_done_s, w_done_s;
`ifdef RIP_AXI_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  hs_s;
`endif

  // Next-state, grant and channel-control logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    err_d        = err_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    // On a tie the requester that did not win last time gets the grant.
    gnt_idx_s    = (req == 2'b11) ? ~last_grant_q : req[1];
    // A channel counts as finished once its valid has been accepted.
    aw_done_s    = ~awvalid_q | m_axi.awready;
    w_done_s     = ~wvalid_q  | m_axi.wready;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          ack_d[gnt_idx_s] = 1'b1;
          last_grant_d     = gnt_idx_s;
          idx_d            = gnt_idx_s;
          addr_d  = gnt_idx_s ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH]   : addr[ADDR_WIDTH-1:0];
          wdata_d = gnt_idx_s ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
          wstrb_d = gnt_idx_s ? wstrb[2*STRB_W-1:STRB_W]         : wstrb[STRB_W-1:0];
          if (we[gnt_idx_s]) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      RDATA: begin
        if (m_axi.rvalid) begin
          rready_d       = 1'b0;
          rdata_d        = m_axi.rdata;
          err_d          = (m_axi.rresp != 2'b00);
          done_d[idx_q]  = 1'b1;
          state_d        = IDLE;
        end else begin
          rready_d = 1'b1;
        end
      end
      WADDR: begin
        awvalid_d = awvalid_q & ~m_axi.awready;
        wvalid_d  = wvalid_q  & ~m_axi.wready;
        if (aw_done_s && w_done_s) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end else begin
          state_d  = WADDR;
        end
      end
      WRESP: begin
        if (m_axi.bvalid) begin
          bready_d      = 1'b0;
          err_d         = (m_axi.bresp != 2'b00);
          done_d[idx_q] = 1'b1;
          state_d       = IDLE;
        end else begin
          bready_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase

`ifdef RIP_AXI_ARB_TIMEOUT_EN
    hs_s = (arvalid_q & m_axi.arready) | (rready_q & m_axi.rvalid) |
           (awvalid_q & m_axi.awready) | (wvalid_q & m_axi.wready) |
           (bready_q & m_axi.bvalid);
    if (state_q == IDLE) begin
      timer_d = {TMR_W{1'b0}};
    end else if (hs_s) begin
      timer_d = {TMR_W{1'b0}};
    end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      // Watchdog expired: abandon the bus and report an error completion.
      timer_d       = {TMR_W{1'b0}};
      state_d       = IDLE;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      done_d        = 2'b00;
      done_d[idx_q] = 1'b1;
      err_d         = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      wstrb_q      <= {STRB_W{1'b0}};
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      rdata_q      <= {DATA_WIDTH{1'b0}};
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
`ifdef RIP_AXI_ARB_TIMEOUT_EN
      timer_q      <= {TMR_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
`ifdef RIP_AXI_ARB_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign ack   = ack_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

  // Single-beat, 4-byte INCR transfers; the ID carries the granted index.
  assign m_axi.awid     = {{(AXI_ID_WIDTH-1){1'b0}}, idx_q};
  assign m_axi.awaddr   = addr_q;
  assign m_axi.awlen    = 8'd0;
  assign m_axi.awsize   = 3'b010;
  assign m_axi.awburst  = 2'b01;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = 4'd0;
  assign m_axi.awprot   = 3'd0;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;
  assign m_axi.awvalid  = awvalid_q;
  assign m_axi.wid      = {{(AXI_ID_WIDTH-1){1'b0}}, idx_q};
  assign m_axi.wdata    = wdata_q;
  assign m_axi.wstrb    = wstrb_q;
  assign m_axi.wlast    = 1'b1;
  assign m_axi.wvalid   = wvalid_q;
  assign m_axi.bready   = bready_q;
  assign m_axi.arid     = {{(AXI_ID_WIDTH-1){1'b0}}, idx_q};
  assign m_axi.araddr   = addr_q;
  assign m_axi.arlen    = 8'd0;
  assign m_axi.arsize   = 3'b010;
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'd0;
  assign m_axi.arprot   = 3'd0;
  assign m_axi.arqos    = 4'd0;
  assign m_axi.arregion = 4'd0;
  assign m_axi.arvalid  = arvalid_q;
  assign m_axi.rready   = rready_q;

endmodule

// File: tb/tb_rip_axi_arbiter.sv
// tb_rip_axi_arbiter
//   Directed bench for rip_axi_arbiter: the bench plays the AXI slave and the
//   two requesters, and checks every observation with immediate assertions.
//   Define RIP_AXI_ARB_TIMEOUT_EN to build the watchdog variant (TIMEOUT=16).
module tb_rip_axi_arbiter;

`ifdef RIP_AXI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [63:0] addr, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  ack, done;
  logic [31:0] rdata;
  logic        err, busy;
  int          total = 0;
  int          bad   = 0;

  rip_axi_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

  rip_axi_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_ID_WIDTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ack(ack), .done(done), .rdata(rdata), .err(err),
    .busy(busy), .m_axi(axi.master)
  );

  always #5 clk = ~clk;

  // advance one clock; sample/drive 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // zero-wait read: DUT is in IDLE with req set now (grant cycle N)
  task automatic rd_txn(input int idx, input logic [31:0] exp_addr,
                        input logic [31:0] d, input logic [1:0] resp,
                        input logic [1:0] nreq);
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    step();                                   // N+1
    check("rd_ack", ack, oh);
    check("rd_arvalid", axi.arvalid, 1);
    check("rd_araddr", axi.araddr, exp_addr);
    check("rd_arid", axi.arid, idx);
    check("rd_busy", busy, 1);
    req = nreq;
    axi.arready = 1'b1;
    step();                                   // N+2
    check("rd_arvalid_drop", axi.arvalid, 0);
    check("rd_rready", axi.rready, 1);
    check("rd_ack_pulse", ack, 2'b00);
    check("rd_done_early", done, 2'b00);
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = d;
    axi.rresp   = resp;
    axi.rlast   = 1'b1;
    step();                                   // N+3
    check("rd_done", done, oh);
    check("rd_rdata", rdata, d);
    check("rd_err", err, (resp != 2'b00));
    check("rd_rready_drop", axi.rready, 0);
    axi.rvalid = 1'b0;
    axi.rdata  = 32'h0;
    axi.rresp  = 2'b00;
    axi.rlast  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr = 64'h0; wdata = 64'h0; wstrb = 8'h0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = 4'h0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    axi.arready = 1'b0;
    axi.rid = 4'h0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rvalid = 1'b0;
    step();
    step();
    // reset state
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b000);
    check("rst_readies", {axi.rready, axi.bready}, 2'b00);
    rst = 1'b0;

    // round-robin with both requests held: grants 0,1,0
    addr = {32'h0000_2000, 32'h0000_1000};
    req  = 2'b11;
    rd_txn(0, 32'h0000_1000, 32'hA0A0_0001, 2'b00, 2'b11);
    rd_txn(1, 32'h0000_2000, 32'hA0A0_0002, 2'b00, 2'b11);
    rd_txn(0, 32'h0000_1000, 32'hA0A0_0003, 2'b00, 2'b00);
    step();
    check("rr_idle_busy", busy, 0);
    check("rr_done_pulse", done, 2'b00);

    // lone read from requester 0, OKAY response
    req = 2'b01;
    rd_txn(0, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 2'b00);
    step();
    check("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

    // read with SLVERR response
    req = 2'b01;
    rd_txn(0, 32'h0000_1000, 32'h0BAD_F00D, 2'b10, 2'b00);
    step();
    check("slverr_err_hold", err, 1);
    check("slverr_done_pulse", done, 2'b00);

    // requester 1 write, WREADY one cycle before AWREADY
    req   = 2'b10; we = 2'b10;
    addr  = {32'h0000_3000, 32'h0000_1000};
    wdata = {32'h1234_5678, 32'hFFFF_FFFF};
    wstrb = 8'hF0;
    step();                                   // N+1
    check("wr_ack", ack, 2'b10);
    check("wr_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    check("wr_awaddr", axi.awaddr, 32'h0000_3000);
    check("wr_awid", axi.awid, 4'h1);
    check("wr_wid", axi.wid, 4'h1);
    check("wr_wdata", axi.wdata, 32'h1234_5678);
    check("wr_wstrb", axi.wstrb, 4'hF);
    check("wr_consts", {axi.wlast, axi.awlen, axi.awsize, axi.awburst}, {1'b1, 8'h00, 3'b010, 2'b01});
    req = 2'b00; we = 2'b00;
    axi.wready = 1'b1;
    step();                                   // N+2
    check("wr_wvalid_first", {axi.awvalid, axi.wvalid}, 2'b10);
    check("wr_bready_early", axi.bready, 0);
    axi.wready  = 1'b0;
    axi.awready = 1'b1;
    step();                                   // N+3
    check("wr_awvalid_drop", axi.awvalid, 0);
    check("wr_bready", axi.bready, 1);
    axi.awready = 1'b0;
    axi.bvalid  = 1'b1;
    axi.bid     = 4'h1;
    axi.bresp   = 2'b00;
    step();                                   // N+4
    check("wr_done", done, 2'b10);
    check("wr_err", err, 0);
    check("wr_bready_drop", axi.bready, 0);
    check("wr_busy", busy, 0);
    axi.bvalid = 1'b0;
    step();
    check("wr_done_pulse", done, 2'b00);

    // reset while waiting in WRESP; AW and W complete in the same cycle
    req = 2'b01; we = 2'b01;
    step();
    check("wr2_ack", ack, 2'b01);
    req = 2'b00; we = 2'b00;
    axi.awready = 1'b1; axi.wready = 1'b1;
    step();
    check("wr2_same_cycle", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
    axi.awready = 1'b0; axi.wready = 1'b0;
    rst = 1'b1;
    req = 2'b11;
    step();
    check("mid_rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b00000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 2'b00);
    check("mid_rst_ack", ack, 2'b00);
    rst = 1'b0;
    // last_grant back to 1, so requester 0 wins the tie
    rd_txn(0, 32'h0000_1000, 32'h5555_AAAA, 2'b00, 2'b00);

`ifdef RIP_AXI_ARB_TIMEOUT_EN
    // watchdog: ARREADY never comes
    req = 2'b01; we = 2'b00;
    step();                                   // N+1, first RADDR cycle
    check("tmo_ack", ack, 2'b01);
    req = 2'b00;
    for (int i = 0; i < 15; i++) step();      // N+16
    check("tmo_done_early", done, 2'b00);
    check("tmo_arvalid_held", axi.arvalid, 1);
    step();                                   // N+17
    check("tmo_done", done, 2'b01);
    check("tmo_err", err, 1);
    check("tmo_arvalid_drop", axi.arvalid, 0);
    check("tmo_busy", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
